streaming_sha256: RTL and testbench
===================================

STREAMING_SHA256 -- requirements
Module: streaming_sha256

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; begin a new message and discard any message in progress.
REQ-005 update  in  1  one-cycle strobe; append the valid bytes of data_in to the message.
REQ-006 data_in  in  32  message bytes, big-endian and left-justified; first byte in [31:24].
REQ-007 bytes_valid  in  3  count of valid bytes in data_in, 1..4, taken from the MSB end.
REQ-008 finalize  in  1  one-cycle pulse; pad, append length, and finish the hash.
REQ-009 hash_valid  out  1  one-cycle pulse when hash is ready.
REQ-010 hash  out  256  SHA-256 digest, H0 in [255:224] through H7 in [31:0].

Function
REQ-011 Implements FIPS 180-4 SHA-256 over a byte stream of arbitrary length, including zero bytes.
REQ-012 Caller protocol: update with bytes_valid<4 only on the last update before finalize; finalize exactly once per message.
REQ-013 Accept update on every clock cycle, back-to-back, with no backpressure.
REQ-014 Buffering: one 16-word input assembly buffer plus a separate compression core holding its own W schedule.
REQ-015 A full input block transfers to the core when the core is idle; the buffer is then free immediately.
REQ-016 The caller shall not complete a further 16-word block while one full block is already waiting behind a busy core.
REQ-017 Idle gaps of any length between updates are allowed.
REQ-018 The core does one round per cycle; a block takes 64 rounds plus 1 load cycle plus 1 add-back cycle, 66 cycles total.
REQ-019 Maintain a 64-bit message bit-length counter, increased by 8*bytes_valid on each update.
REQ-020 Padding: byte 0x80 right after the last message byte, then zero bytes, then the 64-bit big-endian bit length in the last 8 bytes of a block.
REQ-021 If (message bytes mod 64) >= 56, generate one extra block containing only zeros and the length.
REQ-022 finalize may arrive while the core is busy; it is latched as pending and padding is built once the prior block has been consumed.
REQ-023 update and finalize in the same cycle: the data is appended first, then finalize is applied.
REQ-024 start in the same cycle as update or finalize: start wins and the others are ignored.
REQ-025 start mid-operation aborts the current message and reloads H0..H7 with the standard IVs.
REQ-026 hash_valid pulses high for exactly 1 cycle after the add-back of the final block.
REQ-027 hash updates in the same cycle hash_valid is asserted and holds until the next completed digest or rst.
REQ-028 Latency from finalize to hash_valid is at most 2*66+4 cycles; it is deterministic for a given buffer state.
REQ-029 update or finalize with no message active (no start since rst or since the last digest) is ignored.

Reset
REQ-030 rst: hash_valid=0, hash=0, core idle, buffers emptied, length=0, no message active, no pending finalize.
REQ-031 rst takes priority over every other input in the same cycle, including mid-block.

Configuration
REQ-032 Macro STREAMING_SHA256_PROTOCOL_CHECK_EN defined: simulation-only checks report an error on these protocol violations:
- bytes_valid of 0 or greater than 4 with update;
- update after a partial word;
- buffer overrun (REQ-016);
- finalize with no message active.
REQ-033 Macro undefined: no checking logic is present; behaviour on violations is undefined; all other behaviour is identical.

Verification
REQ-034 start; one update "a" (bytes_valid=1); finalize -> hash=ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb.
REQ-035 start; finalize (empty message) -> hash=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-036 64 'A', 16 back-to-back updates -> hash=d53eda7a637c99cc7fb566d96e9fa109bf15c478410a3f5eb4d4c4e26cd081f6.
REQ-037 65 'A' -> 836203944f4c0280461ad73d31457c22ba19d1d99e232dc231000085899e00a2.
REQ-038 63 'A' (length-only extra block) -> 1b58d00f5b1fbd2a1884d666a2be33c2fa7463dff32cd60ef200c0f750a6b70f.
REQ-039 71 'A' -> 96b437b3df7c62fc877a121b087899f5e36a58f6d87ba52d997e92bb016aa575; 79 'A' -> 1581baebc5f9dcfd89c658b3c3303203fc0e2f93e3f9e0b593d8b2b8112c6eda.
REQ-040 128 'A' fed as 14 words, a 50-cycle gap, then 18 words -> b6ac3cc10386331c765f04f041c147d0f278f2aed8eaa021e2d0057fc6f6ff9e.
REQ-041 In REQ-034 to REQ-040, hash_valid is high exactly 1 cycle per message.

Source files
------------

// File: rtl/streaming_sha256.sv
// streaming_sha256
//
// Byte-stream SHA-256 engine. Message bytes arrive as left-justified 32-bit
// words through a 16-word assembly buffer; full blocks are handed to a
// compression core that keeps its own 16-word rolling message schedule, so
// the buffer is free again in the same cycle the core takes a block.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset, overrides everything
//   start        begin a new message, aborting any message in progress
//   update       append bytes_valid bytes of data_in (MSB end first)
//   data_in      message bytes, first byte in [31:24]
//   bytes_valid  1..4 valid bytes; fewer than 4 only on the last update
//   finalize     pad, append the bit length and complete the digest
//   hash_valid   one-cycle pulse when a new digest is on hash
//   hash         digest, H0 in [255:224] .. H7 in [31:0]; held until the
//                next digest or rst
//
// Build option
//   STREAMING_SHA256_PROTOCOL_CHECK_EN  adds simulation-only caller protocol
//   checks (bad bytes_valid, update after a partial word, buffer overrun,
//   finalize with no message active). Without it no checking logic exists.
//
// Front-end states
//   F_IDLE   | no message active; update/finalize ignored
//   F_ACTIVE | accepting updates; a latched finalize builds the pad block
//   F_LENBLK | pad block queued, length-only block still to be built
//   F_DRAIN  | final block queued or in the core, waiting for the digest
//
// Core states
//   C_IDLE   | waiting; taking a full buffer here is the load cycle
//   C_RND    | one compression round per cycle, 64 rounds
//   C_ADD    | add working variables back into H0..H7

module streaming_sha256 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         update,
    input  logic [31:0]  data_in,
    input  logic [2:0]   bytes_valid,
    input  logic         finalize,
    output logic         hash_valid,
    output logic [255:0] hash
);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV_TAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    typedef enum logic [1:0] {F_IDLE, F_ACTIVE, F_LENBLK, F_DRAIN} front_st_e;
    typedef enum logic [1:0] {C_IDLE, C_RND, C_ADD} core_st_e;

    front_st_e     front_q, front_d;
    core_st_e      core_q, core_d;

    logic [31:0]   buf_q [16];
    logic [3:0]    wcnt_q;
    logic          buf_full_q;
    logic          buf_last_q;
    logic [63:0]   len_q;
    logic          fin_pend_q;

    logic [31:0]   w_q [16];
    logic [31:0]   wv_q [8];
    logic [31:0]   h_q [8];
    logic [5:0]    rnd_q;
    logic          core_last_q;

    logic          hash_valid_q;
    logic [255:0]  hash_q;

    logic          take;
    logic          buf_free;
    logic          acc_upd;
    logic          acc_fin;
    logic          do_pad;
    logic          do_len;
    logic          pad_fits;
    logic          done_last;
    logic [5:0]    boff;
    logic [31:0]   keep_mask;
    logic [31:0]   pad_byte;
    logic [31:0]   pad_blk [16];
    logic [31:0]   t1, t2, w_new;
    logic [31:0]   h_sum [8];

    // ---------------------------------------------------------------
    // Handshake between front end and core
    // ---------------------------------------------------------------
    assign take      = (core_q == C_IDLE) && buf_full_q && !start;
    assign buf_free  = !buf_full_q || take;
    assign acc_upd   = update && (front_q == F_ACTIVE) && !fin_pend_q && !start;
    assign acc_fin   = finalize && (front_q == F_ACTIVE) && !fin_pend_q && !start;
    assign do_pad    = fin_pend_q && (front_q == F_ACTIVE) && buf_free && !start;
    assign do_len    = (front_q == F_LENBLK) && buf_free && !start;
    assign done_last = (core_q == C_ADD) && core_last_q && !start;

    // Byte offset of the next message byte inside the current block; the
    // 0x80 marker lands there. Offsets 56..63 leave no room for the length.
    assign boff      = len_q[8:3];
    assign pad_fits  = (boff[5:3] != 3'b111);
    assign keep_mask = ~(32'hFFFF_FFFF >> {boff[1:0], 3'b000});
    assign pad_byte  = 32'h8000_0000 >> {boff[1:0], 3'b000};

    // Words below the marker word are message data; the marker word keeps
    // only its valid leading bytes, so stale bits from a partial update or
    // an unwritten slot never reach the core.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            pad_blk[i] = 32'h0;
            if (4'(i) < boff[5:2]) begin
                pad_blk[i] = buf_q[i];
            end else if (4'(i) == boff[5:2]) begin
                pad_blk[i] = (buf_q[i] & keep_mask) | pad_byte;
            end
        end
        if (pad_fits) begin
            pad_blk[14] = len_q[63:32];
            pad_blk[15] = len_q[31:0];
        end
    end

    // ---------------------------------------------------------------
    // Front-end FSM
    // ---------------------------------------------------------------
    always_comb begin
        front_d = front_q;
        case (front_q)
            F_IDLE:   front_d = F_IDLE;
            F_ACTIVE: if (do_pad) front_d = pad_fits ? F_DRAIN : F_LENBLK;
            F_LENBLK: if (do_len) front_d = F_DRAIN;
            F_DRAIN:  if (done_last) front_d = F_IDLE;
            default:  front_d = F_IDLE;
        endcase
        if (start) begin
            front_d = F_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q <= F_IDLE;
        end else begin
            front_q <= front_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'h0;
            end
            wcnt_q     <= 4'd0;
            buf_full_q <= 1'b0;
            buf_last_q <= 1'b0;
            len_q      <= 64'd0;
            fin_pend_q <= 1'b0;
        end else if (start) begin
            wcnt_q     <= 4'd0;
            buf_full_q <= 1'b0;
            buf_last_q <= 1'b0;
            len_q      <= 64'd0;
            fin_pend_q <= 1'b0;
        end else begin
            if (take) begin
                buf_full_q <= 1'b0;
            end
            if (acc_upd) begin
                buf_q[wcnt_q] <= data_in;
                wcnt_q        <= wcnt_q + 4'd1;
                len_q         <= len_q + {58'd0, bytes_valid, 3'b000};
                // A partial word in slot 15 is the message tail, not a
                // complete block; it is consumed by the pad block instead.
                if (wcnt_q == 4'd15 && bytes_valid == 3'd4) begin
                    buf_full_q <= 1'b1;
                end
            end
            if (acc_fin) begin
                fin_pend_q <= 1'b1;
            end
            if (do_pad) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[i] <= pad_blk[i];
                end
                buf_full_q <= 1'b1;
                buf_last_q <= pad_fits;
                fin_pend_q <= 1'b0;
            end
            if (do_len) begin
                for (int i = 0; i < 14; i++) begin
                    buf_q[i] <= 32'h0;
                end
                buf_q[14]  <= len_q[63:32];
                buf_q[15]  <= len_q[31:0];
                buf_full_q <= 1'b1;
                buf_last_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Compression core
    // ---------------------------------------------------------------
    always_comb begin
        core_d = core_q;
        case (core_q)
            C_IDLE:  if (take) core_d = C_RND;
            C_RND:   if (rnd_q == 6'd63) core_d = C_ADD;
            C_ADD:   core_d = C_IDLE;
            default: core_d = C_IDLE;
        endcase
        if (start) begin
            core_d = C_IDLE;
        end
    end

    always_comb begin
        t1 = wv_q[7] + big_s1(wv_q[4])
           + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
           + K_TAB[rnd_q] + w_q[0];
        t2 = big_s0(wv_q[0])
           + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
        // w_q[0] is W[t]; the window slides so w_q[k] is W[t+k].
        w_new = sml_s1(w_q[14]) + w_q[9] + sml_s0(w_q[1]) + w_q[0];
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = h_q[i] + wv_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_q <= C_IDLE;
        end else begin
            core_q <= core_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h0;
            end
            for (int i = 0; i < 8; i++) begin
                wv_q[i] <= 32'h0;
                h_q[i]  <= 32'h0;
            end
            rnd_q       <= 6'd0;
            core_last_q <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= IV_TAB[i];
            end
            rnd_q       <= 6'd0;
            core_last_q <= 1'b0;
        end else if (take) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= buf_q[i];
            end
            for (int i = 0; i < 8; i++) begin
                wv_q[i] <= h_q[i];
            end
            rnd_q       <= 6'd0;
            core_last_q <= buf_last_q;
        end else if (core_q == C_RND) begin
            for (int i = 0; i < 15; i++) begin
                w_q[i] <= w_q[i + 1];
            end
            w_q[15] <= w_new;
            wv_q[7] <= wv_q[6];
            wv_q[6] <= wv_q[5];
            wv_q[5] <= wv_q[4];
            wv_q[4] <= wv_q[3] + t1;
            wv_q[3] <= wv_q[2];
            wv_q[2] <= wv_q[1];
            wv_q[1] <= wv_q[0];
            wv_q[0] <= t1 + t2;
            rnd_q   <= rnd_q + 6'd1;
        end else if (core_q == C_ADD) begin
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= h_sum[i];
            end
        end
    end

    // ---------------------------------------------------------------
    // Digest output
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_valid_q <= 1'b0;
            hash_q       <= 256'h0;
        end else begin
            hash_valid_q <= done_last;
            if (done_last) begin
                hash_q <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                           h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
            end
        end
    end

    assign hash_valid = hash_valid_q;
    assign hash       = hash_q;

`ifdef STREAMING_SHA256_PROTOCOL_CHECK_EN
    logic partial_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            partial_q <= 1'b0;
        end else if (acc_upd && bytes_valid != 3'd4) begin
            partial_q <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst && !start) begin
            if (update && (bytes_valid == 3'd0 || bytes_valid > 3'd4))
                $error("streaming_sha256: update with bytes_valid=%0d", bytes_valid);
            if (acc_upd && partial_q)
                $error("streaming_sha256: update after a partial word");
            if (acc_upd && buf_full_q && !take)
                $error("streaming_sha256: input buffer overrun");
            if (finalize && front_q == F_IDLE)
                $error("streaming_sha256: finalize with no message active");
        end
    end
`endif

endmodule

// File: tb/tb_streaming_sha256.sv
module tb_streaming_sha256;

    logic         clk;
    logic         rst;
    logic         start;
    logic         update;
    logic [31:0]  data_in;
    logic [2:0]   bytes_valid;
    logic         finalize;
    logic         hash_valid;
    logic [255:0] hash;

    int n_checks = 0;
    int n_errors = 0;
    int hv_total = 0;
    int hv_base  = 0;

    localparam logic [255:0] H_A     = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
    localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] H_A64   = 256'hd53eda7a637c99cc7fb566d96e9fa109bf15c478410a3f5eb4d4c4e26cd081f6;
    localparam logic [255:0] H_A65   = 256'h836203944f4c0280461ad73d31457c22ba19d1d99e232dc231000085899e00a2;
    localparam logic [255:0] H_A63   = 256'h1b58d00f5b1fbd2a1884d666a2be33c2fa7463dff32cd60ef200c0f750a6b70f;
    localparam logic [255:0] H_A71   = 256'h96b437b3df7c62fc877a121b087899f5e36a58f6d87ba52d997e92bb016aa575;
    localparam logic [255:0] H_A79   = 256'h1581baebc5f9dcfd89c658b3c3303203fc0e2f93e3f9e0b593d8b2b8112c6eda;
    localparam logic [255:0] H_A128  = 256'hb6ac3cc10386331c765f04f041c147d0f278f2aed8eaa021e2d0057fc6f6ff9e;

    streaming_sha256 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .update      (update),
        .data_in     (data_in),
        .bytes_valid (bytes_valid),
        .finalize    (finalize),
        .hash_valid  (hash_valid),
        .hash        (hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hash_valid) hv_total++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_digest(input string tag, input bit chk_lat, input logic [255:0] exp);
        int lat = 0;
        bit got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (hash_valid) got = 1'b1;
        end
        check_val({tag, "_done"}, 256'(got), 256'd1);
        check_val({tag, "_hash"}, hash, exp);
        if (chk_lat) check_val({tag, "_lat_le136"}, 256'(lat <= 136), 256'd1);
        repeat (5) @(negedge clk);
        check_val({tag, "_pulses"}, 256'(hv_total - hv_base), 256'd1);
        check_val({tag, "_hold"}, hash, exp);
        #1;
    endtask

    // Sends nbytes copies of bval; a short final word carries 0xA5 filler
    // in its invalid bytes.
    task automatic run_msg(input string tag, input int nbytes, input logic [7:0] bval,
                           input int gap_after, input int gap_len, input bit fin_with_last,
                           input bit chk_lat, input logic [255:0] exp);
        int rem;
        int nw;
        logic [31:0] mask;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        hv_base = hv_total;
        rem = nbytes;
        nw = 0;
        while (rem > 0) begin
            update = 1'b1;
            if (rem >= 4) begin
                bytes_valid = 3'd4;
                data_in = {bval, bval, bval, bval};
                rem -= 4;
            end else begin
                bytes_valid = 3'(rem);
                mask = 32'hFFFF_FFFF << (8 * (4 - rem));
                data_in = ({bval, bval, bval, bval} & mask) | (32'hA5A5_A5A5 & ~mask);
                rem = 0;
            end
            nw++;
            if (rem == 0 && fin_with_last) finalize = 1'b1;
            tick();
            update = 1'b0;
            finalize = 1'b0;
            if (nw == gap_after) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        if (!fin_with_last || nbytes == 0) begin
            finalize = 1'b1;
            tick();
            finalize = 1'b0;
        end
        wait_digest(tag, chk_lat, exp);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        update = 1'b0;
        finalize = 1'b0;
        data_in = 32'h0;
        bytes_valid = 3'd0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_hash", hash, 256'h0);
        check_val("rst_valid", 256'(hash_valid), 256'd0);

        // No message active: update and finalize are ignored.
        tick();
        hv_base = hv_total;
        update = 1'b1; bytes_valid = 3'd4; data_in = 32'h4141_4141;
        tick();
        update = 1'b0; finalize = 1'b1;
        tick();
        finalize = 1'b0;
        repeat (150) tick();
        check_val("idle_ignored_pulses", 256'(hv_total - hv_base), 256'd0);
        check_val("idle_ignored_hash", hash, 256'h0);

        run_msg("abc_a",  1, 8'h61, -1, 0, 1'b0, 1'b1, H_A);
        run_msg("empty",  0, 8'h41, -1, 0, 1'b0, 1'b1, H_EMPTY);
        run_msg("a64",   64, 8'h41, -1, 0, 1'b0, 1'b1, H_A64);
        run_msg("a65",   65, 8'h41, -1, 0, 1'b1, 1'b0, H_A65);
        run_msg("a63",   63, 8'h41, -1, 0, 1'b1, 1'b1, H_A63);
        run_msg("a71",   71, 8'h41, -1, 0, 1'b0, 1'b0, H_A71);
        run_msg("a79",   79, 8'h41, -1, 0, 1'b1, 1'b0, H_A79);
        run_msg("a128", 128, 8'h41, 14, 50, 1'b0, 1'b0, H_A128);

        // After a digest the message is closed again.
        hv_base = hv_total;
        update = 1'b1; bytes_valid = 3'd4; data_in = 32'h4242_4242; finalize = 1'b1;
        tick();
        update = 1'b0; finalize = 1'b0;
        repeat (150) tick();
        check_val("post_digest_pulses", 256'(hv_total - hv_base), 256'd0);
        check_val("post_digest_hash", hash, H_A128);

        // Abort mid-block; the restarting start also carries update and
        // finalize that must be dropped.
        start = 1'b1;
        tick();
        start = 1'b0;
        hv_base = hv_total;
        for (int i = 0; i < 20; i++) begin
            update = 1'b1; bytes_valid = 3'd4; data_in = 32'h4242_4242;
            tick();
        end
        update = 1'b0;
        repeat (5) tick();
        start = 1'b1; update = 1'b1; bytes_valid = 3'd4; data_in = 32'hDEAD_BEEF; finalize = 1'b1;
        tick();
        start = 1'b0; finalize = 1'b0;
        update = 1'b1; bytes_valid = 3'd1; data_in = 32'h61C3_C3C3;
        tick();
        update = 1'b0; finalize = 1'b1;
        tick();
        finalize = 1'b0;
        wait_digest("abort", 1'b1, H_A);

        // Reset while the core is mid-block.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            update = 1'b1; bytes_valid = 3'd4; data_in = 32'h4343_4343;
            tick();
        end
        update = 1'b0;
        repeat (10) tick();
        hv_base = hv_total;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_hash", hash, 256'h0);
        check_val("midrst_valid", 256'(hash_valid), 256'd0);
        repeat (100) tick();
        check_val("midrst_pulses", 256'(hv_total - hv_base), 256'd0);
        run_msg("empty_after_rst", 0, 8'h41, -1, 0, 1'b0, 1'b1, H_EMPTY);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
